// File: rtl/ssd_scan_pkg.sv
// Shared definitions for the seven-segment scan readback logic.
// Holds the active-low segment patterns {g,f,e,d,c,b,a} for each hex digit
// and for an all-off digit, the scan FSM state type, and a helper that sizes
// the digit-index field from the number of anode lines.
package ssd_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_CAPTURED = 2'd2
  } scan_state_t;

  // Width of a digit index; never narrower than one bit.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/ssd_scan_decoder_decode.sv
// ssd_pattern_decode: combinational seven-segment pattern decoder.
// Ports:
//   seg      - active-low cathodes {g,f,e,d,c,b,a}
//   nibble   - decoded hex value (0 when not a hex pattern)
//   is_blank - pattern is all segments off
//   is_legal - pattern is one of the sixteen hex glyphs
module ssd_pattern_decode
  import ssd_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_legal
);

  always_comb begin
    nibble   = '0;
    is_blank = 1'b0;
    is_legal = 1'b1;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        is_blank = 1'b1;
        is_legal = 1'b0;
      end
      default:   is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: readback monitor for a multiplexed seven-segment display.
// Deglitches each anode dwell, decodes the segment pattern of the lit digit
// and publishes one complete frame of digits each time the scan wraps.
// Ports:
//   ssd_scan_decoder_clk        - system clock
//   ssd_scan_decoder_rst        - asynchronous reset, active-low
//   ssd_scan_decoder_seg        - active-low cathodes {g,f,e,d,c,b,a}
//   ssd_scan_decoder_an         - active-low anode selects, one-cold when lit
//   ssd_scan_decoder_value      - published nibbles, digit i at [4i+3:4i]
//   ssd_scan_decoder_valid      - digit captured a hex pattern last frame
//   ssd_scan_decoder_blank      - digit captured all-off last frame
//   ssd_scan_decoder_frame_done - one-cycle pulse per published frame
//   ssd_scan_decoder_error      - sticky: illegal pattern or multi-cold anode
module ssd_scan_decoder
  import ssd_scan_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                ssd_scan_decoder_clk,
  input  logic                ssd_scan_decoder_rst,
  input  logic [6:0]          ssd_scan_decoder_seg,
  input  logic [DIGITS-1:0]   ssd_scan_decoder_an,
  output logic [4*DIGITS-1:0] ssd_scan_decoder_value,
  output logic [DIGITS-1:0]   ssd_scan_decoder_valid,
  output logic [DIGITS-1:0]   ssd_scan_decoder_blank,
  output logic                ssd_scan_decoder_frame_done,
  output logic                ssd_scan_decoder_error
);

  localparam int         IW          = idx_width(DIGITS);
  localparam logic [3:0] CNT_CAPTURE = 4'(STABLE_CYCLES);

  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   an_q;
  scan_state_t         state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                capture;
  logic                fsm_err;

  logic [DIGITS-1:0]   lit;
  logic                pair_same;
  logic                lit_one;
  logic                lit_multi;
  logic [IW-1:0]       idx;

  logic [3:0]          dec_nibble;
  logic                dec_blank;
  logic                dec_legal;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [DIGITS-1:0]   bmask_q, bmask_d;
  logic                publish;
  logic                cap_err;

  // Decisions are taken on the sample being registered at this edge, compared
  // against the pair registered at the previous edge. That makes the first
  // edge of a new pair count 1, so capture lands STABLE_CYCLES-1 edges later.
  assign lit       = ~ssd_scan_decoder_an;
  assign pair_same = (ssd_scan_decoder_seg == seg_q) && (ssd_scan_decoder_an == an_q);
  assign lit_multi = (lit & (lit - DIGITS'(1))) != '0;
  assign lit_one   = (lit != '0) && !lit_multi;

  always_ff @(posedge ssd_scan_decoder_clk or negedge ssd_scan_decoder_rst) begin
    if (!ssd_scan_decoder_rst) begin
      seg_q   <= '0;
      an_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      seg_q   <= ssd_scan_decoder_seg;
      an_q    <= ssd_scan_decoder_an;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fsm_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lit_one) begin
          state_d = S_SETTLE;
          cnt_d   = 4'd1;
        end else if (lit_multi) begin
          fsm_err = 1'b1;
        end
      end
      S_SETTLE, S_CAPTURED: begin
        if (!pair_same) begin
          if (lit_one) begin
            state_d = S_SETTLE;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            fsm_err = lit_multi;
          end
        end else if (state_q == S_SETTLE) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == CNT_CAPTURE) begin
            capture = 1'b1;
            state_d = S_CAPTURED;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // At capture the live pair equals the registered pair, so the registered
  // copy is used for the digit index and the pattern.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) idx = IW'(i);
    end
  end

  ssd_pattern_decode u_decode (
    .seg      (seg_q),
    .nibble   (dec_nibble),
    .is_blank (dec_blank),
    .is_legal (dec_legal)
  );

  // A capture of a digit already seen closes the frame before being recorded
  // as the first digit of the next one.
  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    bmask_d  = bmask_q;
    publish  = 1'b0;
    cap_err  = 1'b0;
    if (capture) begin
      if (seen_q[idx]) begin
        publish  = 1'b1;
        shadow_d = '0;
        seen_d   = '0;
        bmask_d  = '0;
      end
      if (dec_legal) begin
        shadow_d[4*idx +: 4] = dec_nibble;
        seen_d[idx]          = 1'b1;
        bmask_d[idx]         = 1'b0;
      end else if (dec_blank) begin
        shadow_d[4*idx +: 4] = 4'h0;
        seen_d[idx]          = 1'b1;
        bmask_d[idx]         = 1'b1;
      end else begin
        cap_err = 1'b1;
      end
    end
  end

  always_ff @(posedge ssd_scan_decoder_clk or negedge ssd_scan_decoder_rst) begin
    if (!ssd_scan_decoder_rst) begin
      shadow_q                    <= '0;
      seen_q                      <= '0;
      bmask_q                     <= '0;
      ssd_scan_decoder_value      <= '0;
      ssd_scan_decoder_valid      <= '0;
      ssd_scan_decoder_blank      <= '0;
      ssd_scan_decoder_frame_done <= 1'b0;
      ssd_scan_decoder_error      <= 1'b0;
    end else begin
      shadow_q                    <= shadow_d;
      seen_q                      <= seen_d;
      bmask_q                     <= bmask_d;
      ssd_scan_decoder_frame_done <= publish;
      if (publish) begin
        ssd_scan_decoder_value <= shadow_q;
        ssd_scan_decoder_valid <= seen_q & ~bmask_q;
        ssd_scan_decoder_blank <= seen_q & bmask_q;
      end
      if (fsm_err || cap_err) ssd_scan_decoder_error <= 1'b1;
    end
  end

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the design's multiplexed seven-segment driver.
- Watches the active-low cathode bus and active-low anode bus and deglitches each anode dwell.
- Decodes each segment pattern back to a hex nibble and publishes a complete scanned frame of digits.
- Used in self-checking benches and as an on-chip display readback monitor.

Parameters:
DIGITS, 8, number of anode lines / digit slots monitored
STABLE_CYCLES, 4, consecutive edges an (anode, segment) pair must hold before capture (legal 2..15)

Ports:
ssd_scan_decoder_clk  input  1  system clock
ssd_scan_decoder_rst  input  1  asynchronous reset, active-low
ssd_scan_decoder_seg  input  7  cathodes {g,f,e,d,c,b,a}, active-low
ssd_scan_decoder_an  input  DIGITS  anode selects, active-low, one-cold when a digit is lit
ssd_scan_decoder_value  output  4*DIGITS  published nibbles; digit i in bits [4i+3:4i]
ssd_scan_decoder_valid  output  DIGITS  digit i captured a legal hex pattern in the last published frame
ssd_scan_decoder_blank  output  DIGITS  digit i captured all-off (7'h7F) in the last published frame
ssd_scan_decoder_frame_done  output  1  one-cycle pulse when a frame is published
ssd_scan_decoder_error  output  1  sticky error flag

Behaviour:
- Async reset, active-low: all outputs 0, shadow registers 0, seen-mask 0, FSM to IDLE, counter 0.
- Reset asserted mid-frame discards the partial frame.
- Input stage: seg and an are registered every edge with no synchroniser. The stability counter compares each new sample with the previous registered pair.
- Decode table (seg hex -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
  - 7F -> blank
  - any other pattern is illegal
- FSM IDLE:
  - wait for the registered an to be one-cold.
  - an all-ones: stay in IDLE, no error.
  - an multi-cold (two or more zeros): set error, stay in IDLE.
  - one-cold an: go to SETTLE with counter = 1.
- FSM SETTLE:
  - each edge with the pair unchanged increments the counter.
  - any change restarts the count at 1 with the new pair. If the new an is all-ones or multi-cold, go to IDLE with the IDLE rules applied.
  - when the counter reaches STABLE_CYCLES, capture and go to CAPTURED.
  - timing: a pair first presented before edge k is captured at edge k+STABLE_CYCLES-1.
- Capture of digit i, where i is the index of the zero bit in an:
  - if seen[i] is already 1, the frame closes first:
    - outputs are loaded from the shadow registers; valid and blank are loaded from the seen-mask split by the blank bit.
    - frame_done pulses on the next edge.
    - seen-mask and shadow clear; the new capture becomes the first of the next frame.
  - legal hex pattern: shadow[i] = nibble, seen[i] = 1, blank bit 0.
  - blank pattern: shadow[i] = 0, seen[i] = 1, blank bit 1.
  - illegal pattern: error set, seen[i] not set, shadow[i] unchanged.
- FSM CAPTURED: hold until the registered pair changes. This gives exactly one capture per dwell. The change is then handled as in SETTLE.
- Outputs change only on frame publication, except error.
- Error clears only on reset.
- Digits never scanned in a frame publish valid = 0, blank = 0, value nibble 0.

Decomposition:
- Shared package ssd_scan_pkg holds:
  - localparam segment constants SEG_0..SEG_F and SEG_BLANK;
  - FSM state encodings S_IDLE, S_SETTLE, S_CAPTURED (2-bit);
  - width helper for the digit index, clog2(DIGITS).
- One natural sub-module, ssd_pattern_decode. It is combinational: 7-bit seg in; nibble, is_blank and is_legal out. It is shared with future encoder-check logic.

Test Plan:
- Reset then scan 8 digits, an=FE..7F, each dwell 8 cycles, seg sequence 40,79,24,30,19,12,02,78 -> after the wrap to an=FE: value=32'h76543210, valid=FF, blank=00, one frame_done pulse, error=0.
- 2-digit scan (an=FE/FD), seg 79/46, STABLE_CYCLES=4 -> value[7:0]=8'hC1, valid=03; capture occurs exactly 3 edges after the first registered sample.
- Glitch: 1-cycle seg=00 between dwells, then 3-cycle dwells (< STABLE_CYCLES) -> no capture, no frame_done, outputs unchanged.
- Illegal seg 7'h55 on digit 2, and separately an=FC -> error=1 and stays 1; valid[2]=0 in the next frame; error persists until ssd_scan_decoder_rst=0.
- Blank: seg=7F on digit 1, digit 0 = 06 -> valid=01, blank=02, value[3:0]=E.
- Assert rst low mid-frame after 3 captures -> all outputs 0 immediately (asynchronous); the next full scan publishes only freshly captured digits.
